shift_add_mul: RTL



---
 rtl/shift_add_mul.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul (with Adder, 16-bit carry-look-ahead adder)
// Brief    : Sequential unsigned 16x16->32 shift-add multiplier, one partial
//            product per clock, valid/ready on operands and result.
// Revision : 1.0 - initial release
// ============================================================================

module Adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] rslt,
  output logic        cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Two-level lookahead: 4-bit groups, then a lookahead across the groups.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int c_base = gi * 4;
      assign w_c[c_base]   = w_gc[gi];
      assign w_c[c_base+1] = w_g[c_base] | (w_p[c_base] & w_gc[gi]);
      assign w_c[c_base+2] = w_g[c_base+1]
                           | (w_p[c_base+1] & w_g[c_base])
                           | (w_p[c_base+1] & w_p[c_base] & w_gc[gi]);
      assign w_c[c_base+3] = w_g[c_base+2]
                           | (w_p[c_base+2] & w_g[c_base+1])
                           | (w_p[c_base+2] & w_p[c_base+1] & w_g[c_base])
                           | (w_p[c_base+2] & w_p[c_base+1] & w_p[c_base] & w_gc[gi]);
      assign w_gg[gi] = w_g[c_base+3]
                      | (w_p[c_base+3] & w_g[c_base+2])
                      | (w_p[c_base+3] & w_p[c_base+2] & w_g[c_base+1])
                      | (w_p[c_base+3] & w_p[c_base+2] & w_p[c_base+1] & w_g[c_base]);
      assign w_gp[gi] = &w_p[c_base+3:c_base];
    end
  endgenerate

  assign w_gc[0] = 1'b0;
  assign w_gc[1] = w_gg[0];
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);

  assign rslt = w_p ^ w_c;
  assign cout = w_gc[4];

endmodule

module shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_last_iter = 5'd15;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_acc;
  logic [4:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_prod;

  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH:0]       w_partial;
  logic [WIDTH-1:0]     w_acc_next;
  logic [WIDTH-1:0]     w_q_next;

  Adder u_adder (
    .A    (r_acc),
    .B    (r_m),
    .rslt (w_sum),
    .cout (w_cout)
  );

  // 17-bit partial sum keeps the carry; shifting it right by one feeds its
  // LSB into the top of Q while the carry lands in ACC[15].
  assign w_partial  = r_q[0] ? {w_cout, w_sum} : {1'b0, r_acc};
  assign w_acc_next = w_partial[WIDTH:1];
  assign w_q_next   = {w_partial[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs decode from state only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == c_last_iter) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m    <= '0;
      r_q    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m   <= A;
            r_q   <= B;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_last_iter) begin
            r_prod <= {w_acc_next, w_q_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign prod = r_prod;

endmodule

`default_nettype wire
